// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types and constants for the vending controller:
//                controller state enum, coin codes, coin unit values and a
//                helper that maps a coin code to its value in units.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Coin codes presented on din
    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_ONE    = 2'b01;
    localparam logic [1:0] COIN_TWO    = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    // Value of each coin code in units (1 unit = 5c)
    localparam logic [1:0] UNITS_NONE = 2'd0;
    localparam logic [1:0] UNITS_ONE  = 2'd1;
    localparam logic [1:0] UNITS_TWO  = 2'd2;

    // Cancel carries no value; it is decoded separately
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        logic [1:0] units;
        units = UNITS_NONE;
        case (code)
            COIN_ONE: units = UNITS_ONE;
            COIN_TWO: units = UNITS_TWO;
            default:  units = UNITS_NONE;
        endcase
        return units;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_idle_timer
//  Description : Counts consecutive enabled cycles; 'expired' is asserted
//                combinationally on the cycle whose edge would complete the
//                TIMEOUT-th enabled cycle. 'clr' has priority over 'en'.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry fires on the edge that completes the TIMEOUT-th idle cycle
    always_comb begin
        expired = en && !clr && (count_q == C_LAST);
        count_d = count_q;
        if (clr || expired) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vend_controller
//  Description : Vending sequencer. Accumulates coin credit, handshakes the
//                dispenser (disp_req/disp_ack), then pays change one unit coin
//                per cycle. All pulse outputs are registered.
//                Optional COLLECT idle refund built when VEND_TIMEOUT_EN is
//                defined; otherwise tmo is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          din,
    input  logic                disp_ack,
    output logic                p,
    output logic                disp_req,
    output logic                coin_out,
    output logic                coin_reject,
    output logic                tmo,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // Price at register width and one bit wider (for overflow-safe compares)
    localparam logic [CREDIT_W-1:0] C_PRICE      = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   C_PRICE_WIDE = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0]   C_CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state_q;
    state_t              state_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                p_q;
    logic                p_d;
    logic                coin_out_q;
    logic                coin_out_d;
    logic                coin_reject_q;
    logic                coin_reject_d;
    logic                tmo_q;
    logic                tmo_d;

    logic [1:0]          w_units;
    logic                w_is_coin;
    logic                w_cancel;
    logic [CREDIT_W:0]   w_sum;
    logic                w_overflow;
    logic                w_tmo_fire;

    // Coin decode and one-bit-wider sum so overflow is visible
    always_comb begin
        w_units    = coin_units(din);
        w_is_coin  = (w_units != UNITS_NONE);
        w_cancel   = (din == COIN_CANCEL);
        w_sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(w_units);
        w_overflow = (w_sum > C_CREDIT_MAX);
    end

`ifdef VEND_TIMEOUT_EN
    logic w_tmr_en;
    logic w_tmr_clr;

    // Idle counting only while in COLLECT with no coin code presented
    always_comb begin
        w_tmr_en  = (state_q == COLLECT) && (din == COIN_NONE);
        w_tmr_clr = (state_q != COLLECT) || (din != COIN_NONE);
    end

    vend_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmo_fire)
    );
`else
    // No idle refund: COLLECT waits indefinitely
    assign w_tmo_fire = 1'b0;
`endif

    // State and credit register plus registered pulse outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            p_q           <= 1'b0;
            coin_out_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            p_q           <= p_d;
            coin_out_q    <= coin_out_d;
            coin_reject_q <= coin_reject_d;
            tmo_q         <= tmo_d;
        end
    end

    // Next state and next credit
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (w_is_coin) begin
                    credit_d = CREDIT_W'(w_units);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (w_is_coin) begin
                    if (!w_overflow) begin
                        credit_d = w_sum[CREDIT_W-1:0];
                        if (w_sum >= C_PRICE_WIDE) begin
                            state_d = DISPENSE;
                        end
                    end
                end else if (w_cancel || w_tmo_fire) begin
                    state_d = CHANGE;
                end
            end
            DISPENSE: begin
                // Credit >= PRICE is guaranteed on entry, so no underflow
                if (disp_ack) begin
                    credit_d = credit_q - C_PRICE;
                    state_d  = (credit_q == C_PRICE) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Output decode: next-cycle pulses and state-derived levels
    always_comb begin
        p_d           = (state_q == DISPENSE) && disp_ack;
        coin_out_d    = (state_q == CHANGE);
        coin_reject_d = w_is_coin &&
                        (((state_q == COLLECT) && w_overflow) ||
                         (state_q == DISPENSE) ||
                         (state_q == CHANGE));
        tmo_d         = w_tmo_fire;
        disp_req      = (state_q == DISPENSE);
        busy          = (state_q == DISPENSE) || (state_q == CHANGE);
    end

    assign p           = p_q;
    assign coin_out    = coin_out_q;
    assign coin_reject = coin_reject_q;
    assign tmo         = tmo_q;
    assign credit      = credit_q;

endmodule
`default_nettype wire

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the vending datapath: accepts coin codes, accumulates credit, drives a dispenser through a request/acknowledge handshake, then returns change one coin per cycle. It sits between the coin-slot decoder and the dispenser/change-hopper actuators, replacing a flat Mealy vending FSM with an explicit credit register and handshaked actuator control.

## Interface
- PRICE, 3: item price in coin units (1 unit = 5c); legal range 1..(2**CREDIT_W - 3)
- CREDIT_W, 4: credit register width
- TIMEOUT, 16: idle cycles in COLLECT before automatic refund (used only with VEND_TIMEOUT_EN)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- din  in  2  coin code, sampled every edge: 00 none, 01 one unit, 10 two units, 11 cancel
- disp_ack  in  1  dispenser done, level, honoured only in DISPENSE
- p  out  1  one-cycle pulse: item delivered
- disp_req  out  1  dispenser request, held high for all of DISPENSE
- coin_out  out  1  one-cycle pulse per returned unit coin
- coin_reject  out  1  one-cycle pulse: inserted coin refused (returned mechanically)
- tmo  out  1  one-cycle pulse: timeout refund started
- credit  out  CREDIT_W  current credit in units
- busy  out  1  high in DISPENSE or CHANGE

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE: credit 0. din 01/10 → credit += value, go to COLLECT. din 11 is ignored.
- COLLECT: coin adds to credit. If the updated credit ≥ PRICE → DISPENSE. din 11 → CHANGE (full refund, no item).
- A coin that would exceed 2**CREDIT_W-1 is rejected: coin_reject pulses and credit is unchanged.
- DISPENSE: disp_req=1. Any coin is rejected (coin_reject). din 11 is ignored.
  - On disp_ack: p pulses, credit -= PRICE, then → CHANGE if the remainder > 0, else → IDLE.
- CHANGE: coin_out=1 every cycle and credit decrements by 1 each cycle. The cycle that sets credit to 0 goes → IDLE. Coins are rejected; cancel is ignored.
- Arithmetic is unsigned at CREDIT_W. Subtraction never underflows, because DISPENSE is entered only with credit ≥ PRICE.
- Only one din code per cycle; there are no simultaneous coin+cancel.

## Timing
- Reset (synchronous, any state, including mid-DISPENSE/CHANGE): state IDLE, credit 0, and all outputs 0 on the next edge. A pending disp_ack is discarded.
- p, coin_out, coin_reject and tmo are registered one-cycle pulses.
- Coin accepted at edge N:
  - credit updates at N.
  - If credit ≥ PRICE, disp_req is high from N.
- disp_ack sampled high at edge M:
  - p=1 and disp_req=0 during cycle M..M+1.
  - The first coin_out is in the cycle after M+1.
- Refund of k units: exactly k consecutive coin_out cycles.
- disp_ack is held high → only one dispense per entry into DISPENSE. disp_ack outside DISPENSE has no effect.

## Configuration
- VEND_TIMEOUT_EN defined:
  - An idle counter runs in COLLECT. It clears on any din≠00 and on state change.
  - On reaching TIMEOUT: tmo pulses and the state goes → CHANGE (full refund).
  - Exactly TIMEOUT consecutive din=00 cycles after the last coin trigger it.
- Undefined: no counter is built, tmo is tied 0, and COLLECT waits indefinitely.

## Structure
- Package vend_pkg holds:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE)
  - coin-code localparams COIN_NONE=2'b00, COIN_ONE=2'b01, COIN_TWO=2'b10, COIN_CANCEL=2'b11
  - unit value localparams
- Sub-module vend_idle_timer (parameter TIMEOUT; ports clock, reset, clr, en, expired). It is instantiated only under VEND_TIMEOUT_EN.

## Test plan
- Reset, then din 01,01,01 on three edges:
  - credit 1,2,3.
  - disp_req high after the third edge.
  - disp_ack after 2 cycles → p=1 for one cycle, credit 0, no coin_out, IDLE.
- din 10,10:
  - credit 4 → DISPENSE.
  - ack → p, credit 1, then exactly one coin_out, IDLE.
- din 01, then 11 → one coin_out, p never high, IDLE.
- din 10,01, then din 10 while disp_req=1 → coin_reject one cycle, credit stays 3.
- VEND_TIMEOUT_EN, TIMEOUT=16: din 10 then 16 cycles of 00 → tmo pulse, two coin_out, IDLE.
  - Without the macro, the same stimulus → credit stays 2 and tmo stays 0.
- Reset asserted during the second coin_out of a 3-unit refund → next edge: credit 0, coin_out 0, busy 0, IDLE.
